lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Owns the HD44780-class LCD pins: runs power-on init, then arbitrates write requests from two requesters, e.g. the screen-painter FSM (port 0) and the CPU Wishbone LCD bridge (port 1).
- Generates setup, E-pulse, hold and execution-wait timing so requesters only present a byte plus a command/data flag.
- Sits between the wb_lcd requesters and the LCD pins; write-only, so the busy flag is never read.

Parameters:
- T_PWR, 300000, power-on wait in clk_20m cycles before init (15 ms at 20 MHz).
- T_SU, 2, cycles RS/DB are stable before E rises.
- T_EPW, 10, cycles E is high.
- T_HOLD, 2, cycles RS/DB are held after E falls.
- T_EXEC, 800, execution wait after a normal command or data byte (40 us).
- T_CLR, 32800, execution wait after clear/home, i.e. rs=0 and byte 0x01..0x03 (1.64 ms).
- CW, 20, width of the timing counter; must hold max(T_PWR, T_CLR).

Ports:
- clk_20m  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request, level.
- rs0  in  1  port 0 flag: 1 = data, 0 = command.
- dat0  in  8  port 0 byte.
- ack0  out  1  one-cycle pulse: port 0 byte latched.
- req1, rs1, dat1, ack1: as port 0, for port 1.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  LCD RW, constant 0.
- lcd_e  out  1  LCD enable.
- lcd_db  out  8  LCD data bus.
- busy  out  1  high in every state except IDLE.
- init_done  out  1  high once init completes; cleared only by rst.

Behaviour:
- All outputs registered, all updates on posedge clk_20m.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, ack0=ack1=0, busy=1, init_done=0, state=PWR_WAIT, counter=0, last_grant=1, init_idx=0.
- States:
  - PWR_WAIT: count T_PWR cycles, then go to SETUP with internal byte init_rom[init_idx], rs=0.
  - SETUP: RS/DB driven from the latched byte, E=0, lasts T_SU cycles, then E_HIGH.
  - E_HIGH: E=1 for T_EPW cycles, then HOLD.
  - HOLD: E=0, RS/DB unchanged for T_HOLD cycles, then EXEC_WAIT.
  - EXEC_WAIT: wait T_CLR cycles if the latched rs=0 and byte is in 0x01..0x03, otherwise T_EXEC cycles.
    - During init: if init_idx<4, increment it and go to SETUP with the next init byte; else set init_done=1 and go to IDLE.
    - After init: go to IDLE.
  - IDLE: busy=0; grant on any pending request, otherwise stay.
- Init ROM: 0x38, 0x38, 0x0C, 0x06, 0x01 (8-bit, 2 lines, display on/cursor off, entry increment, clear). No acks during init; requests stay pending.
- Arbitration (IDLE only):
  - If only one req is high, grant it.
  - If both are high, grant the port != last_grant (round robin); after reset port 0 wins the first tie.
  - On grant, latch rs/dat of the winner, update last_grant, and pulse that port's ack for exactly one cycle, coincident with the first SETUP cycle.
- Handshake: the requester holds req/rs/dat stable until it samples ack=1. It then either drops req or presents the next byte with req held high; the next byte is served after the current transfer completes.
- Latency: req high in IDLE at cycle n gives ack and SETUP at n+1 and E rise at n+1+T_SU. Transfer length from SETUP entry to IDLE is T_SU+T_EPW+T_HOLD+Texec. IDLE lasts at least 1 cycle between transfers.
- Counter: loads 0 on each state entry; the state exits when counter == T-1.
- lcd_db/lcd_rs keep their last value while IDLE; lcd_e is never high outside E_HIGH.
- Reset mid-operation: next cycle lcd_e=0 and all reset values apply; init replays fully; the in-flight byte is dropped and its port is not re-acked.
- A req asserted and dropped before grant is lost with no ack; a requester must not do this.

Test Plan (T_PWR=20, T_SU=2, T_EPW=3, T_HOLD=1, T_EXEC=5, T_CLR=12):
- Reset, no requests -> busy=1; 5 E pulses with lcd_db=0x38,0x38,0x0C,0x06,0x01 (rs=0), each 3 cycles high; last wait is 12 cycles; then init_done=1, busy=0.
- Port 0 requests data 0x41 during init -> no ack until init_done. Then: ack0 one cycle; lcd_rs=1, lcd_db=0x41; E rises 2 cycles after ack0; IDLE 11 cycles after ack0.
- req0 and req1 rise in the same IDLE cycle, both held for 3 bytes -> grants alternate 0,1,0,1,0,1; each ack is exactly 1 cycle.
- Port 1 sends cmd 0x01 then cmd 0x80 -> wait after 0x01 is 12 cycles and after 0x80 is 5 cycles (measured E fall+hold to IDLE).
- rst pulsed for 1 cycle while lcd_e=1 -> lcd_e=0 next cycle, init_done=0, init sequence replays from 0x38, no extra ack.
- Port 0 streams 4 bytes with req held high -> 4 acks, minimum spacing 12 cycles; lcd_rw=0 throughout.

Source files
------------

// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: requester handshakes and LCD pin bundle for lcd_bus_arbiter
interface lcd_bus_arbiter_if;
  logic       req0, rs0, ack0;
  logic       req1, rs1, ack1;
  logic [7:0] dat0, dat1;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;
  logic       busy, init_done;
  modport master (
    output req0, rs0, dat0, req1, rs1, dat1,
    input  ack0, ack1, lcd_rs, lcd_rw, lcd_e, lcd_db, busy, init_done
  );
  modport slave (
    input  req0, rs0, dat0, req1, rs1, dat1,
    output ack0, ack1, lcd_rs, lcd_rw, lcd_e, lcd_db, busy, init_done
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: HD44780 power-on init plus round-robin write arbitration of two requesters
module lcd_bus_arbiter #(
  parameter int T_PWR  = 300000,
  parameter int T_SU   = 2,
  parameter int T_EPW  = 10,
  parameter int T_HOLD = 2,
  parameter int T_EXEC = 800,
  parameter int T_CLR  = 32800,
  parameter int CW     = 20
) (
  input logic             clk_20m,
  input logic             rst,
  lcd_bus_arbiter_if.slave bus
);
  typedef enum logic [2:0] {PWR_WAIT, SETUP, E_HIGH, HOLD, EXEC_WAIT, IDLE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    db_q, db_d;
  logic          rs_q, rs_d, e_q, e_d, last_q, last_d, done_q, done_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
  logic          clr, tdone, g0, g1;
  function automatic logic [7:0] rom(input logic [2:0] i);
    return i < 3'd2 ? 8'h38 : i == 3'd2 ? 8'h0C : i == 3'd3 ? 8'h06 : 8'h01;
  endfunction
  // next-state, latched byte, arbitration and registered-output values
  always_comb begin
    clr    = !rs_q && db_q != 8'h00 && db_q <= 8'h03;
    lim    = state_q == PWR_WAIT ? CW'(T_PWR - 1) :
             state_q == SETUP    ? CW'(T_SU - 1)  :
             state_q == E_HIGH   ? CW'(T_EPW - 1) :
             state_q == HOLD     ? CW'(T_HOLD - 1) :
             clr                 ? CW'(T_CLR - 1) : CW'(T_EXEC - 1);
    tdone  = cnt_q == lim;
    g0     = bus.req0 && (!bus.req1 || last_q);
    g1     = bus.req1 && !g0;
    state_d = state_q;
    idx_d   = idx_q;
    db_d    = db_q;
    rs_d    = rs_q;
    last_d  = last_q;
    done_d  = done_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      PWR_WAIT: if (tdone) begin
        state_d = SETUP;
        rs_d    = 1'b0;
        db_d    = rom(idx_q);
      end
      SETUP:  if (tdone) state_d = E_HIGH;
      E_HIGH: if (tdone) state_d = HOLD;
      HOLD:   if (tdone) state_d = EXEC_WAIT;
      EXEC_WAIT: if (tdone) begin
        if (done_q) state_d = IDLE;
        else if (idx_q < 3'd4) begin
          idx_d   = idx_q + 3'd1;
          db_d    = rom(idx_q + 3'd1);
          state_d = SETUP;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: if (g0 || g1) begin
        state_d = SETUP;
        last_d  = g1;
        rs_d    = g1 ? bus.rs1 : bus.rs0;
        db_d    = g1 ? bus.dat1 : bus.dat0;
        ack0_d  = g0;
        ack1_d  = g1;
      end
    endcase
    cnt_d  = state_d != state_q ? '0 : cnt_q + 1'b1;
    e_d    = state_d == E_HIGH;
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk_20m) begin
    if (rst) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      db_q    <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      db_q    <= db_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_e     = e_q;
  assign bus.lcd_db    = db_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = done_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed checks of init, arbitration, timing and reset of lcd_bus_arbiter
module tb_lcd_bus_arbiter;
  localparam int T_HOLD = 1;
  logic clk_20m = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  lcd_bus_arbiter_if bus();
  lcd_bus_arbiter #(.T_PWR(20), .T_SU(2), .T_EPW(3), .T_HOLD(T_HOLD), .T_EXEC(5), .T_CLR(12)) dut (
    .clk_20m(clk_20m), .rst(rst), .bus(bus.slave)
  );
  always #5 clk_20m = ~clk_20m;
  // cycle index for latency measurements
  always @(posedge clk_20m) cyc <= cyc + 1;
  logic [8:0] elog[$];
  int ewid[$], gaps[$], acks[$];
  int ehi = 0, fall_cyc = 0, wide = 0, rw_bad = 0;
  logic e_p = 1'b0, b_p = 1'b1, a0_p = 1'b0, a1_p = 1'b0;
  // bus monitor: logs E pulses, their widths, exec waits and acks
  always @(negedge clk_20m) begin
    if (bus.lcd_e && !e_p) begin
      elog.push_back({bus.lcd_rs, bus.lcd_db});
      ehi = 0;
    end
    if (bus.lcd_e) ehi++;
    if (!bus.lcd_e && e_p) begin
      ewid.push_back(ehi);
      fall_cyc = cyc;
    end
    if (!bus.busy && b_p) gaps.push_back(cyc - fall_cyc - T_HOLD);
    if (bus.ack0) acks.push_back(0);
    if (bus.ack1) acks.push_back(1);
    if ((bus.ack0 && a0_p) || (bus.ack1 && a1_p)) wide++;
    if (bus.lcd_rw !== 1'b0) rw_bad++;
    e_p  = bus.lcd_e;
    b_p  = bus.busy;
    a0_p = bus.ack0;
    a1_p = bus.ack1;
  end
  task automatic step();
    @(negedge clk_20m);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] init_b [5] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    int ta, ng, na, ne, c0, c1;
    int t[4];
    bus.req0 = 0; bus.rs0 = 0; bus.dat0 = 0;
    bus.req1 = 0; bus.rs1 = 0; bus.dat1 = 0;
    step(); step();
    chk("rst_busy", bus.busy, 1);
    chk("rst_e", bus.lcd_e, 0);
    chk("rst_done", bus.init_done, 0);
    chk("rst_db", bus.lcd_db, 0);
    chk("rst_rs", bus.lcd_rs, 0);
    chk("rst_ack", {bus.ack0, bus.ack1}, 0);
    rst = 0;
    bus.req0 = 1; bus.rs0 = 1; bus.dat0 = 8'h41;
    for (int i = 0; i < 400 && !bus.init_done; i++) step();
    chk("init_to", bus.init_done, 1);
    chk("init_noack", acks.size(), 0);
    chk("init_cnt", elog.size(), 5);
    for (int k = 0; k < 5 && k < elog.size(); k++) chk("init_byte", elog[k], {1'b0, init_b[k]});
    for (int k = 0; k < 5 && k < ewid.size(); k++) chk("init_ewid", ewid[k], 3);
    chk("init_gaps", gaps.size(), 1);
    if (gaps.size() > 0) chk("init_clr_wait", gaps[gaps.size()-1], 12);
    chk("init_busy", bus.busy, 0);
    for (int i = 0; i < 50 && !bus.ack0; i++) step();
    chk("p0_ack_to", bus.ack0, 1);
    ta = cyc;
    chk("p0_rs", bus.lcd_rs, 1);
    chk("p0_db", bus.lcd_db, 8'h41);
    bus.req0 = 0;
    step();
    chk("p0_ack_width", bus.ack0, 0);
    for (int i = 0; i < 50 && !bus.lcd_e; i++) step();
    chk("p0_e_lat", cyc - ta, 2);
    for (int i = 0; i < 50 && bus.busy; i++) step();
    chk("p0_idle_lat", cyc - ta, 11);
    step(); step();
    ng = gaps.size();
    bus.req1 = 1; bus.rs1 = 0; bus.dat1 = 8'h01;
    for (int i = 0; i < 50 && !bus.ack1; i++) step();
    chk("p1_ack_to", bus.ack1, 1);
    chk("p1_rs", bus.lcd_rs, 0);
    chk("p1_db_clr", bus.lcd_db, 8'h01);
    bus.dat1 = 8'h80;
    step();
    for (int i = 0; i < 50 && !bus.ack1; i++) step();
    chk("p1_ack2_to", bus.ack1, 1);
    chk("p1_db_ddram", bus.lcd_db, 8'h80);
    bus.req1 = 0;
    step();
    for (int i = 0; i < 50 && bus.busy; i++) step();
    chk("p1_gaps", gaps.size() - ng, 2);
    if (gaps.size() >= ng + 2) begin
      chk("p1_clr_wait", gaps[ng], 12);
      chk("p1_exec_wait", gaps[ng+1], 5);
    end
    step(); step();
    c0 = 0; c1 = 0;
    bus.req0 = 1; bus.rs0 = 1; bus.dat0 = 8'hA0;
    bus.req1 = 1; bus.rs1 = 1; bus.dat1 = 8'hB0;
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 60 && !(bus.ack0 || bus.ack1); i++) step();
      chk("tie_ack_to", bus.ack0 | bus.ack1, 1);
      chk("tie_order", bus.ack1, g % 2);
      if (bus.ack1) begin
        c1++;
        if (c1 == 3) bus.req1 = 0; else bus.dat1 = bus.dat1 + 8'h01;
      end else begin
        c0++;
        if (c0 == 3) bus.req0 = 0; else bus.dat0 = bus.dat0 + 8'h01;
      end
      step();
    end
    for (int i = 0; i < 50 && bus.busy; i++) step();
    chk("tie_ack_wide", wide, 0);
    step(); step();
    bus.req0 = 1; bus.rs0 = 1; bus.dat0 = 8'h55;
    for (int i = 0; i < 50 && !bus.ack0; i++) step();
    chk("rr_ack_to", bus.ack0, 1);
    bus.req0 = 0;
    for (int i = 0; i < 50 && !bus.lcd_e; i++) step();
    chk("rr_e_to", bus.lcd_e, 1);
    rst = 1;
    step();
    chk("rr_e", bus.lcd_e, 0);
    chk("rr_done", bus.init_done, 0);
    chk("rr_busy", bus.busy, 1);
    chk("rr_db", bus.lcd_db, 0);
    rst = 0;
    na = acks.size();
    ne = elog.size();
    for (int i = 0; i < 400 && !bus.init_done; i++) step();
    chk("rr_init_to", bus.init_done, 1);
    chk("rr_init_cnt", elog.size() - ne, 5);
    if (elog.size() > ne) chk("rr_first", elog[ne], 9'h038);
    for (int i = 0; i < 20; i++) step();
    chk("rr_noack", acks.size(), na);
    na = acks.size();
    bus.req0 = 1; bus.rs0 = 1; bus.dat0 = 8'h30;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 60 && !bus.ack0; i++) step();
      chk("st_ack_to", bus.ack0, 1);
      t[k] = cyc;
      if (k == 3) bus.req0 = 0; else bus.dat0 = bus.dat0 + 8'h01;
      step();
    end
    for (int k = 1; k < 4; k++) chk("st_spacing", t[k] - t[k-1], 12);
    chk("st_acks", acks.size() - na, 4);
    for (int i = 0; i < 50 && bus.busy; i++) step();
    chk("st_byte_last", elog[elog.size()-1], 9'h133);
    chk("rw_low", rw_bad, 0);
    chk("ack_wide", wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
